response_control_mc: RTL and testbench

Parametrised multi-channel successor to the single-slot PSL response router. Sits between the PSL response interface and the compute-unit command engines. It latches each PSL response and resolves its channel from the tag-buffer lookup. Each response is pushed into a per-channel FIFO drained with a valid/ready handshake. Tag parity, response-code errors, FIFO overflow and unroutable responses are reported as a registered error vector plus a sticky copy.

---
 rtl/response_control_mc_pkg.sv | 53 +++++
 rtl/response_control_mc_fifo.sv | 62 ++++++
 rtl/response_control_mc.sv | 139 +++++++++++++
 tb/tb_response_control_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_control_mc_pkg.sv
// Shared types and constants for the multi-channel PSL response router:
// response codes, error-vector layout and the code-to-error decode.
package response_control_mc_pkg;

    typedef enum logic [7:0] {
        RESP_DONE    = 8'h00,
        RESP_AERROR  = 8'h01,
        RESP_DERROR  = 8'h03,
        RESP_NLOCK   = 8'h04,
        RESP_NRES    = 8'h05,
        RESP_FLUSHED = 8'h06,
        RESP_FAULT   = 8'h07,
        RESP_FAILED  = 8'h08,
        RESP_PAGED   = 8'h0A,
        RESP_CONTEXT = 8'h0B
    } response_code_e;

    // Default-width queue entry layout seen by command engines.
    localparam int PSL_TAG_WIDTH = 8;
    typedef struct packed {
        logic [PSL_TAG_WIDTH-1:0] tag;
        logic [7:0]               code;
    } response_entry_t;

    typedef logic [0:8] response_error_t;

    localparam int ERR_PARITY     = 0;
    localparam int ERR_AERROR     = 1;
    localparam int ERR_DERROR     = 2;
    localparam int ERR_FAILED     = 3;
    localparam int ERR_FAULT      = 4;
    localparam int ERR_NRES       = 5;
    localparam int ERR_PAGED      = 6;
    localparam int ERR_OVERFLOW   = 7;
    localparam int ERR_UNROUTABLE = 8;

    // Error bits 1..6 for a response code; benign codes decode to zero.
    function automatic logic [1:6] response_code_error(input logic [7:0] code);
        logic [1:6] err;
        err = '0;
        case (code)
            RESP_AERROR: err[ERR_AERROR] = 1'b1;
            RESP_DERROR: err[ERR_DERROR] = 1'b1;
            RESP_FAILED: err[ERR_FAILED] = 1'b1;
            RESP_FAULT:  err[ERR_FAULT]  = 1'b1;
            RESP_NRES:   err[ERR_NRES]   = 1'b1;
            RESP_PAGED:  err[ERR_PAGED]  = 1'b1;
            default:     err = '0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/response_control_mc_fifo.sv
// Per-channel response FIFO: first-word fall-through from registered storage,
// a push into a full FIFO is accepted when the same cycle pops.
module response_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int PTR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0]     mem_reg [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_WIDTH'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_WIDTH'(1);
                2'b01:   count_reg <= count_reg - CNT_WIDTH'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is forced to zero while empty so stale storage never shows.
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/response_control_mc.sv
// Multi-channel PSL response router: latch, route by tag-buffer channel into
// per-channel FIFOs, report errors. Tag parity checking under RESPONSE_PARITY_CHECK_EN.
module response_control_mc
    import response_control_mc_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int TAG_WIDTH    = 8,
    localparam int CH_WIDTH    = $clog2(NUM_CHANNELS) + 1,
    localparam int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enabled,
    input  logic                              response_valid,
    input  logic [TAG_WIDTH-1:0]              response_tag,
    input  logic                              response_tag_parity,
    input  logic [7:0]                        response_code,
    input  logic [CH_WIDTH-1:0]               lookup_channel,
    output logic [NUM_CHANNELS-1:0]           out_valid,
    input  logic [NUM_CHANNELS-1:0]           out_ready,
    output logic [NUM_CHANNELS*TAG_WIDTH-1:0] out_tag,
    output logic [NUM_CHANNELS*8-1:0]         out_code,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0] out_count,
    output logic [0:8]                        response_error,
    output logic [0:8]                        error_sticky,
    input  logic                              error_clear
);

    localparam int ENTRY_WIDTH = TAG_WIDTH + 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [7:0]           code;
    } response_in_t;

    response_in_t          response_in_reg;
    response_error_t       response_error_reg;
    response_error_t       response_error_next;
    response_error_t       error_sticky_reg;
    logic                  routable;
    logic                  parity_error;
    logic [NUM_CHANNELS-1:0] overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            response_in_reg <= '0;
        end else begin
            response_in_reg.valid <= enabled && response_valid;
            response_in_reg.tag   <= response_tag;
            response_in_reg.code  <= response_code;
        end
    end

`ifdef RESPONSE_PARITY_CHECK_EN
    logic parity_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= response_tag_parity;
        end
    end

    // Odd parity: tag plus parity bit must hold an odd number of ones.
    assign parity_error = ~(^{response_in_reg.tag, parity_reg});
`else
    logic unused_parity;
    assign unused_parity = response_tag_parity;
    assign parity_error  = 1'b0;
`endif

    // The MSB-set case is covered too: it always encodes a value >= NUM_CHANNELS.
    assign routable = (32'(lookup_channel) < NUM_CHANNELS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
            logic                   push;
            logic                   full;
            logic                   empty;
            logic [ENTRY_WIDTH-1:0] head;

            assign push = response_in_reg.valid && routable
                          && (lookup_channel == CH_WIDTH'(gi));
            // A full FIFO always has out_valid high, so pop == out_ready.
            assign overflow[gi] = push && full && !out_ready[gi];

            response_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (ENTRY_WIDTH)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push),
                .push_data ({response_in_reg.tag, response_in_reg.code}),
                .pop       (out_ready[gi]),
                .head_data (head),
                .full      (full),
                .empty     (empty),
                .count     (out_count[gi*CNT_WIDTH +: CNT_WIDTH])
            );

            assign out_valid[gi]                      = !empty;
            assign out_tag[gi*TAG_WIDTH +: TAG_WIDTH] = head[ENTRY_WIDTH-1 -: TAG_WIDTH];
            assign out_code[gi*8 +: 8]                = head[7:0];
        end
    endgenerate

    always_comb begin
        response_error_next = '0;
        if (response_in_reg.valid) begin
            response_error_next[ERR_PARITY]            = parity_error;
            response_error_next[ERR_AERROR:ERR_PAGED]  = response_code_error(response_in_reg.code);
            response_error_next[ERR_OVERFLOW]          = |overflow;
            response_error_next[ERR_UNROUTABLE]        = !routable;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            response_error_reg <= '0;
            error_sticky_reg   <= '0;
        end else begin
            response_error_reg <= response_error_next;
            if (error_clear) begin
                error_sticky_reg <= '0;
            end else begin
                error_sticky_reg <= error_sticky_reg | response_error_reg;
            end
        end
    end

    assign response_error = response_error_reg;
    assign error_sticky   = error_sticky_reg;

endmodule

// File: tb/tb_response_control_mc.sv
// Scoreboard bench for response_control_mc: per-channel expected queues fed by
// a behavioural model, checked against DUT heads, counts and error vectors.
module tb_response_control_mc;

    localparam int NC    = 4;
    localparam int DEPTH = 16;
    localparam int TW    = 8;
    localparam int CHW   = 3;
    localparam int CNTW  = 5;

    logic              clock;
    logic              reset;
    logic              enabled;
    logic              response_valid;
    logic [TW-1:0]     response_tag;
    logic              response_tag_parity;
    logic [7:0]        response_code;
    logic [CHW-1:0]    lookup_channel;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic [NC*TW-1:0]  out_tag;
    logic [NC*8-1:0]   out_code;
    logic [NC*CNTW-1:0] out_count;
    logic [0:8]        response_error;
    logic [0:8]        error_sticky;
    logic              error_clear;

    response_control_mc #(
        .NUM_CHANNELS (NC),
        .FIFO_DEPTH   (DEPTH),
        .TAG_WIDTH    (TW)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enabled             (enabled),
        .response_valid      (response_valid),
        .response_tag        (response_tag),
        .response_tag_parity (response_tag_parity),
        .response_code       (response_code),
        .lookup_channel      (lookup_channel),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_tag             (out_tag),
        .out_code            (out_code),
        .out_count           (out_count),
        .response_error      (response_error),
        .error_sticky        (error_sticky),
        .error_clear         (error_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [7:0] tag;
        logic [7:0] code;
    } ent_t;

    ent_t       q[NC][$];
    bit         lat_v = 0;
    logic [7:0] lat_tag, lat_code;
    logic       lat_par;
    logic [0:8] exp_err = '0;
    logic [0:8] exp_sticky = '0;

    initial begin
        @(posedge clock);
        started = 1;
    end

    always @(negedge clock) begin
        logic [0:8] e;
        int  sz0[NC];
        bit  popped[NC];
        int  ch;
        ent_t item;
        if (started) begin
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(q[c].size() != 0));
                chk($sformatf("out_count[%0d]", c), 32'(out_count[c*CNTW +: CNTW]), q[c].size());
                if (q[c].size() != 0) begin
                    chk($sformatf("out_tag[%0d]", c), 32'(out_tag[c*TW +: TW]), 32'(q[c][0].tag));
                    chk($sformatf("out_code[%0d]", c), 32'(out_code[c*8 +: 8]), 32'(q[c][0].code));
                end
            end
            chk("response_error", 32'(response_error), 32'(exp_err));
            chk("error_sticky", 32'(error_sticky), 32'(exp_sticky));

            if (reset) begin
                for (int c = 0; c < NC; c++) q[c].delete();
                lat_v      = 0;
                exp_err    = '0;
                exp_sticky = '0;
            end else begin
                e = '0;
                for (int c = 0; c < NC; c++) begin
                    sz0[c]    = q[c].size();
                    popped[c] = (sz0[c] > 0) && out_ready[c];
                    if (popped[c]) void'(q[c].pop_front());
                end
                if (lat_v) begin
`ifdef RESPONSE_PARITY_CHECK_EN
                    e[0] = (($countones(lat_tag) + int'(lat_par)) % 2) == 0;
`endif
                    case (lat_code)
                        8'h01: e[1] = 1'b1;
                        8'h03: e[2] = 1'b1;
                        8'h08: e[3] = 1'b1;
                        8'h07: e[4] = 1'b1;
                        8'h05: e[5] = 1'b1;
                        8'h0A: e[6] = 1'b1;
                        default: ;
                    endcase
                    ch = int'(lookup_channel);
                    if (ch >= NC) begin
                        e[8] = 1'b1;
                    end else if (sz0[ch] == DEPTH && !popped[ch]) begin
                        e[7] = 1'b1;
                    end else begin
                        item.tag  = lat_tag;
                        item.code = lat_code;
                        q[ch].push_back(item);
                    end
                end
                exp_sticky = error_clear ? '0 : (exp_sticky | exp_err);
                exp_err    = e;
                lat_v      = enabled && response_valid;
                lat_tag    = response_tag;
                lat_code   = response_code;
                lat_par    = response_tag_parity;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [CHW-1:0] next_ch = '0;

    function automatic logic good_par(input logic [7:0] t);
        return ~(^t);
    endfunction

    // One cycle: lookup for the previously latched response, plus a new response.
    task automatic step(input bit v, input logic [7:0] tag, input logic par,
                        input logic [7:0] code, input logic [CHW-1:0] ch);
        lookup_channel      = next_ch;
        response_valid      = v;
        response_tag        = tag;
        response_tag_parity = par;
        response_code       = code;
        next_ch             = ch;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    logic [7:0] codes [11] = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h0A, 8'h0B, 8'h2C};

    initial begin
        logic [0:8] exp_par_err;
        logic [7:0] t;
        int bias;
        reset = 1'b1; enabled = 1'b1; response_valid = 1'b0; response_tag = '0;
        response_tag_parity = 1'b0; response_code = '0; lookup_channel = '0;
        out_ready = '0; error_clear = 1'b0;
        idle(); idle();
        reset = 1'b0;

        $display("txn: DONE tag 0x2A to channel 1");
        step(1'b1, 8'h2A, good_par(8'h2A), 8'h00, 3'd1);
        idle();
        chk("t1 out_valid[1]", 32'(out_valid[1]), 32'd1);
        chk("t1 out_tag[1]", 32'(out_tag[1*TW +: TW]), 32'h2A);
        chk("t1 out_code[1]", 32'(out_code[1*8 +: 8]), 32'h00);
        chk("t1 response_error", 32'(response_error), 32'd0);
        out_ready[1] = 1'b1; idle(); out_ready[1] = 1'b0;

        $display("txn: fill channel 0 with 16 responses, then one more");
        do_reset();
        for (int i = 0; i < 16; i++) begin
            t = 8'(i + 8'h40);
            step(1'b1, t, good_par(t), 8'h00, 3'd0);
        end
        idle();
        chk("t2 out_count[0] full", 32'(out_count[0 +: CNTW]), 32'd16);
        chk("t2 no errors", 32'(response_error), 32'd0);
        step(1'b1, 8'h77, good_par(8'h77), 8'h00, 3'd0);
        idle();
        chk("t2 overflow", 32'(response_error), 32'(9'b0_0000_0010));
        chk("t2 count held", 32'(out_count[0 +: CNTW]), 32'd16);

        $display("txn: push and pop on full channel 0");
        step(1'b1, 8'h55, good_par(8'h55), 8'h00, 3'd0);
        out_ready[0] = 1'b1; idle(); out_ready[0] = 1'b0;
        chk("t3 count after push+pop", 32'(out_count[0 +: CNTW]), 32'd16);
        chk("t3 no overflow", 32'(response_error), 32'd0);

        $display("txn: bad parity tag 0x01");
        do_reset();
        step(1'b1, 8'h01, 1'b1, 8'h00, 3'd2);
        idle();
`ifdef RESPONSE_PARITY_CHECK_EN
        exp_par_err = 9'b1_0000_0000;
`else
        exp_par_err = 9'b0_0000_0000;
`endif
        chk("t4 parity", 32'(response_error), 32'(exp_par_err));

        $display("txn: FAULT code 0x07, then error_clear");
        step(1'b1, 8'h10, good_par(8'h10), 8'h07, 3'd2);
        idle();
        chk("t5 fault bit", 32'(response_error), 32'(9'b0_0001_0000));
        idle();
        chk("t5 sticky fault", 32'(error_sticky[4]), 32'd1);
        error_clear = 1'b1; idle(); error_clear = 1'b0;
        chk("t5 sticky cleared", 32'(error_sticky), 32'd0);

        $display("txn: unroutable lookup 3'b100");
        do_reset();
        step(1'b1, 8'h33, good_par(8'h33), 8'h00, 3'd4);
        idle();
        chk("t6 unroutable", 32'(response_error), 32'(9'b0_0000_0001));
        chk("t6 no out_valid", 32'(out_valid), 32'd0);

        $display("txn: reset with 5 entries queued on channel 3");
        do_reset();
        for (int i = 0; i < 5; i++) begin
            t = 8'(i + 8'h80);
            step(1'b1, t, good_par(t), 8'h01, 3'd3);
        end
        idle();
        chk("t7 queued", 32'(out_count[3*CNTW +: CNTW]), 32'd5);
        reset = 1'b1; idle(); reset = 1'b0;
        chk("t7 out_valid", 32'(out_valid), 32'd0);
        chk("t7 out_count", 32'(out_count), 32'd0);
        chk("t7 sticky", 32'(error_sticky), 32'd0);

        $display("txn: randomized traffic");
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bias = ($urandom_range(0, 1) != 0) ? 90 : 10;
            for (int c = 0; c < NC; c++) out_ready[c] = ($urandom_range(0, 99) < bias);
            enabled     = ($urandom_range(0, 15) != 0);
            error_clear = ($urandom_range(0, 31) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            t = 8'($urandom);
            step($urandom_range(0, 3) != 0, t,
                 ($urandom_range(0, 9) == 0) ? ~good_par(t) : good_par(t),
                 codes[$urandom_range(0, 10)],
                 ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)));
        end
        reset = 1'b0; enabled = 1'b1; error_clear = 1'b0; out_ready = '1;
        for (int i = 0; i < 40; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
